// File: rtl/stats_pkg.sv
// Shared definitions for the multi-channel stream statistics block:
// counter indices, channel framing states and the clamping adder.
package stats_pkg;

    localparam int CNT_FLIT = 0;
    localparam int CNT_PKT  = 1;
    localparam int CNT_SOP  = 2;
    localparam int CNT_BYTE = 3;
    localparam int CNT_ERR  = 4;
    localparam int NUM_CNT  = 5;

    typedef enum logic {ST_IDLE, ST_INPKT} ch_state_e;

    // Adds two values of width w (<= 64); on overflow either clamps to all-ones or wraps.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w, input bit sat);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim)
            return sat ? lim[63:0] : (sum[63:0] & lim[63:0]);
        return sum[63:0];
    endfunction

endpackage

// File: rtl/stats_ch.sv
// One monitored channel: framing FSM, five live counters and their snapshot shadows.
module stats_ch
    import stats_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DATA_BYTES = 64,
    parameter int EMPTY_W    = 6,
    parameter int SATURATE   = 0
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               beat,
    input  logic               sop,
    input  logic               eop,
    input  logic [EMPTY_W-1:0] empty,
    input  logic               snap,
    input  logic               clr_on_snap,
    input  logic [2:0]         rd_idx,
    output logic [CNT_W-1:0]   rd_val
);

    ch_state_e        state;
    logic             err;
    logic [CNT_W-1:0] live   [NUM_CNT];
    logic [CNT_W-1:0] shadow [NUM_CNT];
    logic [CNT_W-1:0] base   [NUM_CNT];
    logic [CNT_W-1:0] inc    [NUM_CNT];

    // A framing error is a beat without sop outside a packet, or a sop inside one.
    always_comb begin
        err = beat & ((state == ST_IDLE) ? ~sop : sop);
        inc[CNT_FLIT] = CNT_W'(beat);
        inc[CNT_PKT]  = CNT_W'(beat & eop);
        inc[CNT_SOP]  = CNT_W'(beat & sop);
        inc[CNT_BYTE] = '0;
        if (beat)
            inc[CNT_BYTE] = eop ? (CNT_W'(DATA_BYTES) - CNT_W'(empty)) : CNT_W'(DATA_BYTES);
        inc[CNT_ERR]  = CNT_W'(err);
        for (int i = 0; i < NUM_CNT; i++)
            base[i] = (snap & clr_on_snap) ? '0 : live[i];
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            for (int i = 0; i < NUM_CNT; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (snap)
                    shadow[i] <= live[i];
                live[i] <= CNT_W'(sat_add(64'(base[i]), 64'(inc[i]), CNT_W, SATURATE != 0));
            end
            if (beat) begin
                if (sop && !eop)
                    state <= ST_INPKT;
                else if (eop)
                    state <= ST_IDLE;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (rd_idx == 3'(i))
                rd_val = shadow[i];
    end

endmodule

// File: rtl/stats_cnt_mc.sv
// Multi-channel packet/flit/byte statistics with atomic snapshot and 1-cycle read port.
module stats_cnt_mc
    import stats_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CNT_W      = 32,
    parameter int DATA_BYTES = 64,
    parameter int EMPTY_W    = 6,
    parameter int SATURATE   = 0,
    localparam int AW        = $clog2(NCH) + 3
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NCH-1:0]         valid,
    input  logic [NCH-1:0]         ready,
    input  logic [NCH-1:0]         sop,
    input  logic [NCH-1:0]         eop,
    input  logic [NCH*EMPTY_W-1:0] empty,
    input  logic                   snap,
    input  logic                   clr_on_snap,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [CNT_W-1:0]       rd_data,
    output logic                   rd_valid
);

    logic [CNT_W-1:0] ch_val [NCH];
    logic [CNT_W-1:0] rd_sel_p0;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        stats_ch #(
            .CNT_W      (CNT_W),
            .DATA_BYTES (DATA_BYTES),
            .EMPTY_W    (EMPTY_W),
            .SATURATE   (SATURATE)
        ) u_ch (
            .Clk         (Clk),
            .Rst_n       (Rst_n),
            .beat        (valid[g] & ready[g]),
            .sop         (sop[g]),
            .eop         (eop[g]),
            .empty       (empty[g*EMPTY_W +: EMPTY_W]),
            .snap        (snap),
            .clr_on_snap (clr_on_snap),
            .rd_idx      (rd_addr[2:0]),
            .rd_val      (ch_val[g])
        );
    end

    // Channel fields with no matching instance fall through to zero.
    always_comb begin
        rd_sel_p0 = '0;
        for (int c = 0; c < NCH; c++)
            if ((rd_addr >> 3) == AW'(c))
                rd_sel_p0 = ch_val[c];
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_sel_p0;
        end
    end

endmodule

// File: tb/tb_stats_cnt_mc.sv
// Bench for stats_cnt_mc: directed scenarios plus randomized traffic against a counting model.
module tb_stats_cnt_mc;

    localparam int NCH = 4;
    localparam int EW  = 6;
    localparam int AW  = 5;
    localparam int DB  = 64;
    localparam longint unsigned MASK32 = 64'h0000_0000_FFFF_FFFF;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic [NCH-1:0]    valid, ready, sop, eop;
    logic [NCH*EW-1:0] empty;
    logic              snap, clr_on_snap, rd_en;
    logic [AW-1:0]     rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [15:0]       rd_data_s, rd_data_w;
    logic              rd_valid_s, rd_valid_w;

    int total = 0;
    int bad   = 0;

    longint unsigned m_live [NCH][5];
    longint unsigned m_shd  [NCH][5];
    bit              m_inpkt[NCH];

    always #5 Clk = ~Clk;

    stats_cnt_mc #(.NCH(NCH), .CNT_W(32), .DATA_BYTES(DB), .EMPTY_W(EW), .SATURATE(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .valid(valid), .ready(ready), .sop(sop), .eop(eop),
        .empty(empty), .snap(snap), .clr_on_snap(clr_on_snap), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid));

    stats_cnt_mc #(.NCH(NCH), .CNT_W(16), .DATA_BYTES(DB), .EMPTY_W(EW), .SATURATE(1)) dut_sat (
        .Clk(Clk), .Rst_n(Rst_n), .valid(valid), .ready(ready), .sop(sop), .eop(eop),
        .empty(empty), .snap(snap), .clr_on_snap(clr_on_snap), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data_s), .rd_valid(rd_valid_s));

    stats_cnt_mc #(.NCH(NCH), .CNT_W(16), .DATA_BYTES(DB), .EMPTY_W(EW), .SATURATE(0)) dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .valid(valid), .ready(ready), .sop(sop), .eop(eop),
        .empty(empty), .snap(snap), .clr_on_snap(clr_on_snap), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data_w), .rd_valid(rd_valid_w));

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_inpkt[c] = 1'b0;
            for (int i = 0; i < 5; i++) begin
                m_live[c][i] = 0;
                m_shd[c][i]  = 0;
            end
        end
    endfunction

    // Applies this cycle's inputs to the model (32-bit wrapping counters).
    function automatic void model_step();
        int e;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        if (snap) begin
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < 5; i++) begin
                    m_shd[c][i] = m_live[c][i];
                    if (clr_on_snap) m_live[c][i] = 0;
                end
        end
        for (int c = 0; c < NCH; c++) begin
            if (valid[c] && ready[c]) begin
                e = int'(empty[c*EW +: EW]);
                m_live[c][0] += 1;
                if (eop[c]) m_live[c][1] += 1;
                if (sop[c]) m_live[c][2] += 1;
                m_live[c][3] += eop[c] ? longint'(DB - e) : longint'(DB);
                if (m_inpkt[c] ? sop[c] : !sop[c]) m_live[c][4] += 1;
                if (sop[c]) m_inpkt[c] = !eop[c];
                else if (eop[c]) m_inpkt[c] = 1'b0;
                for (int i = 0; i < 5; i++) m_live[c][i] &= MASK32;
            end
        end
    endfunction

    function automatic longint unsigned m_read(input int a);
        int ch, idx;
        ch  = a >> 3;
        idx = a & 7;
        if (ch < NCH && idx < 5) return m_shd[ch][idx];
        return 0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = '0; ready = '0; sop = '0; eop = '0; empty = '0;
        snap = 1'b0; clr_on_snap = 1'b0; rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic beat(input int c, input bit s, input bit e, input int emp);
        valid[c] = 1'b1; ready[c] = 1'b1; sop[c] = s; eop[c] = e;
        empty[c*EW +: EW] = EW'(emp);
        tick();
        idle_inputs();
    endtask

    task automatic do_snap(input bit clr);
        snap = 1'b1; clr_on_snap = clr;
        tick();
        snap = 1'b0; clr_on_snap = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en = 1'b1; rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0 || rd_valid_s !== 1'b0 || rd_data_s !== 16'd0
            || rd_valid_w !== 1'b0 || rd_data_w !== 16'd0) begin
            bad++;
            $display("FAIL reset_out got v=%0b d=%0d vs=%0b ds=%0d vw=%0b dw=%0d want all 0",
                     rd_valid, rd_data, rd_valid_s, rd_data_s, rd_valid_w, rd_data_w);
        end
        rd(3);
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_read got v=%0b d=%0d want v=1 d=0", rd_valid, rd_data);
        end
    endtask

    task automatic test_basic_ch0();
        int exp_v[5] = '{12, 3, 3, 738, 0};
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int f = 0; f < 4; f++)
                beat(0, f == 0, f == 3, (f == 3) ? 10 : 0);
        do_snap(1'b0);
        for (int i = 0; i < 5; i++) begin
            rd(i);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== 32'(exp_v[i])) begin
                bad++;
                $display("FAIL basic_ch0_idx%0d got v=%0b d=%0d want v=1 d=%0d", i, rd_valid, rd_data, exp_v[i]);
            end
        end
        for (int a = 8; a < 32; a++) begin
            rd(a);
            total++;
            if (rd_data !== 32'd0) begin
                bad++;
                $display("FAIL basic_other_addr%0d got %0d want 0", a, rd_data);
            end
        end
    endtask

    task automatic test_framing_ch1();
        int exp_v[5] = '{3, 1, 2, 192, 2};
        do_reset();
        beat(1, 1'b1, 1'b0, 0);
        beat(1, 1'b1, 1'b1, 0);
        beat(1, 1'b0, 1'b0, 0);
        do_snap(1'b0);
        for (int i = 0; i < 5; i++) begin
            rd(8 + i);
            total++;
            if (rd_data !== 32'(exp_v[i])) begin
                bad++;
                $display("FAIL framing_ch1_idx%0d got %0d want %0d", i, rd_data, exp_v[i]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        valid[2] = 1'b1; ready[2] = 1'b1;
        for (int n = 0; n < 1100; n++) tick();
        idle_inputs();
        do_snap(1'b0);
        rd(2*8 + 3);
        total++;
        if (rd_data_s !== 16'd65535 || rd_data_w !== 16'd4864 || rd_data !== 32'd70400) begin
            bad++;
            $display("FAIL sat_byte got sat=%0d wrap=%0d w32=%0d want 65535/4864/70400",
                     rd_data_s, rd_data_w, rd_data);
        end
        rd(2*8);
        total++;
        if (rd_data_s !== 16'd1100 || rd_data_w !== 16'd1100 || rd_data !== 32'd1100) begin
            bad++;
            $display("FAIL sat_flit got sat=%0d wrap=%0d w32=%0d want 1100", rd_data_s, rd_data_w, rd_data);
        end
    endtask

    task automatic test_snap_clr();
        do_reset();
        for (int n = 0; n < 5; n++) beat(0, 1'b1, 1'b1, 0);
        valid[0] = 1'b1; ready[0] = 1'b1; sop[0] = 1'b1; eop[0] = 1'b1;
        snap = 1'b1; clr_on_snap = 1'b1;
        tick();
        idle_inputs();
        rd(0);
        total++;
        if (rd_data !== 32'd5) begin
            bad++;
            $display("FAIL snapclr_first got %0d want 5", rd_data);
        end
        do_snap(1'b0);
        rd(0);
        total++;
        if (rd_data !== 32'd1) begin
            bad++;
            $display("FAIL snapclr_second got %0d want 1", rd_data);
        end
        rd(3);
        total++;
        if (rd_data !== 32'd64) begin
            bad++;
            $display("FAIL snapclr_byte got %0d want 64", rd_data);
        end
    endtask

    task automatic test_all_channels();
        longint unsigned expd;
        logic [31:0] held;
        do_reset();
        for (int n = 0; n < 100; n++) begin
            valid = '1; ready = '1;
            sop = NCH'($urandom); eop = NCH'($urandom); empty = (NCH*EW)'($urandom);
            tick();
        end
        idle_inputs();
        do_snap(1'b0);
        for (int a = 0; a < 32; a++) begin
            expd = m_read(a);
            rd(a);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== expd[31:0]) begin
                bad++;
                $display("FAIL allch_addr%0d got v=%0b d=%0d want v=1 d=%0d", a, rd_valid, rd_data, expd);
            end
            if ((a & 7) == 0) begin
                total++;
                if (rd_data !== 32'd100) begin
                    bad++;
                    $display("FAIL allch_flit_ch%0d got %0d want 100", a >> 3, rd_data);
                end
            end
        end
        held = rd_data;
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== held) begin
            bad++;
            $display("FAIL allch_idle got v=%0b d=%0d want v=0 d=%0d", rd_valid, rd_data, held);
        end
    endtask

    task automatic test_read_during_snap();
        longint unsigned expd;
        for (int n = 0; n < 7; n++) beat(0, 1'b1, 1'b1, 0);
        expd = m_read(0);
        rd_en = 1'b1; rd_addr = '0; snap = 1'b1;
        tick();
        idle_inputs();
        total++;
        if (rd_data !== expd[31:0] || rd_data !== 32'd100) begin
            bad++;
            $display("FAIL rd_snap_same got %0d want %0d", rd_data, expd);
        end
        rd(0);
        total++;
        if (rd_data !== 32'd107) begin
            bad++;
            $display("FAIL rd_snap_after got %0d want 107", rd_data);
        end
    endtask

    task automatic test_random();
        longint unsigned expd;
        logic [31:0] last;
        bit exp_v;
        do_reset();
        last = 32'd0;
        for (int n = 0; n < 600; n++) begin
            valid = NCH'($urandom); ready = NCH'($urandom);
            sop = NCH'($urandom); eop = NCH'($urandom); empty = (NCH*EW)'($urandom);
            snap = ($urandom_range(0, 7) == 0);
            clr_on_snap = 1'($urandom);
            rd_en = 1'($urandom);
            rd_addr = AW'($urandom);
            exp_v = rd_en;
            expd = rd_en ? m_read(int'(rd_addr)) : longint'(last);
            tick();
            total++;
            if (rd_valid !== exp_v || rd_data !== expd[31:0]) begin
                bad++;
                $display("FAIL random_cyc%0d got v=%0b d=%0d want v=%0b d=%0d", n, rd_valid, rd_data, exp_v, expd);
            end
            last = expd[31:0];
        end
        idle_inputs();
        do_snap(1'b0);
        for (int a = 0; a < 32; a++) begin
            expd = m_read(a);
            rd(a);
            total++;
            if (rd_data !== expd[31:0]) begin
                bad++;
                $display("FAIL random_final_addr%0d got %0d want %0d", a, rd_data, expd);
            end
        end
    endtask

    task automatic test_reset_midpkt();
        do_reset();
        beat(3, 1'b1, 1'b0, 0);
        beat(3, 1'b0, 1'b0, 0);
        do_reset();
        do_snap(1'b0);
        rd(24);
        total++;
        if (rd_data !== 32'd0) begin
            bad++;
            $display("FAIL midrst_flit0 got %0d want 0", rd_data);
        end
        beat(3, 1'b0, 1'b0, 0);
        do_snap(1'b0);
        rd(24);
        total++;
        if (rd_data !== 32'd1) begin
            bad++;
            $display("FAIL midrst_flit got %0d want 1", rd_data);
        end
        rd(28);
        total++;
        if (rd_data !== 32'd1) begin
            bad++;
            $display("FAIL midrst_err got %0d want 1", rd_data);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_basic_ch0();
        test_framing_ch1();
        test_saturate();
        test_snap_clr();
        test_all_channels();
        test_read_during_snap();
        test_random();
        test_reset_midpkt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
